// File: rtl/regbank_mp.sv
// Multi-port register file with per-register busy scoreboard and optional zero r0.
// Define REGBANK_BYPASS_EN for combinational write-through forwarding on reads.
module regbank_mp #(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 16,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int ZERO_REG  = 0,
  localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_RD-1:0][AW-1:0]         raddr,
  output logic [NUM_RD-1:0][REG_WIDTH-1:0]  rdata,
  output logic [NUM_RD-1:0]                 rbusy,
  input  logic [NUM_WR-1:0]                 we,
  input  logic [NUM_WR-1:0][AW-1:0]         waddr,
  input  logic [NUM_WR-1:0][REG_WIDTH-1:0]  wdata,
  input  logic                              resv_valid,
  input  logic [AW-1:0]                     resv_addr,
  output logic                              resv_ready,
  output logic                              wr_conflict
);

  logic [REG_WIDTH-1:0] regs [REG_COUNT];
  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_nx;
  logic [NUM_WR-1:0]    wv;
  logic                 conflict;
  logic                 resv_zero;
  logic                 resv_ok;

  function automatic logic in_rng(input logic [AW-1:0] a);
    return 32'(a) < REG_COUNT;
  endfunction

  // Addressable, storable register: in range and not the hardwired r0.
  function automatic logic ok(input logic [AW-1:0] a);
    return in_rng(a) && !(ZERO_REG != 0 && a == '0);
  endfunction

  always_comb begin
    wv       = '0;
    conflict = 1'b0;
    for (int j = 0; j < NUM_WR; j++)
      wv[j] = we[j] & ok(waddr[j]);
    for (int j = 0; j < NUM_WR; j++)
      for (int k = j + 1; k < NUM_WR; k++)
        if (wv[j] && wv[k] && waddr[j] == waddr[k])
          conflict = 1'b1;
  end

  always_comb begin
    resv_zero  = (ZERO_REG != 0) && (resv_addr == '0);
    resv_ok    = ok(resv_addr);
    resv_ready = 1'b0;
    if (resv_valid) begin
      if (resv_zero)
        resv_ready = 1'b1;
      else if (resv_ok)
        resv_ready = ~busy[resv_addr];
    end
  end

  // Writeback clears first, reservation sets last: set wins on same address.
  always_comb begin
    busy_nx = busy;
    for (int j = 0; j < NUM_WR; j++)
      if (wv[j])
        busy_nx[waddr[j]] = 1'b0;
    if (resv_ready && resv_ok)
      busy_nx[resv_addr] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rdata[i] = '0;
      rbusy[i] = 1'b0;
      if (ok(raddr[i])) begin
        rdata[i] = regs[raddr[i]];
        rbusy[i] = busy[raddr[i]];
      end
`ifdef REGBANK_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++)
        if (wv[j] && waddr[j] == raddr[i]) begin
          rdata[i] = wdata[j];
          rbusy[i] = 1'b0;
        end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_COUNT; r++)
        regs[r] <= '0;
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_WR; j++)
        if (wv[j])
          regs[waddr[j]] <= wdata[j];
      busy        <= busy_nx;
      wr_conflict <= conflict;
    end
  end

endmodule

// File: tb/tb_regbank_mp.sv
// Directed bench for regbank_mp: default instance plus a
// 12-entry zero-r0 instance for range and r0 behaviour.
module tb_regbank_mp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0][3:0]  a_raddr;
  logic [1:0][31:0] a_rdata;
  logic [1:0]       a_rbusy;
  logic [1:0]       a_we;
  logic [1:0][3:0]  a_waddr;
  logic [1:0][31:0] a_wdata;
  logic             a_rv;
  logic [3:0]       a_ra;
  logic             a_rr;
  logic             a_wc;

  logic [1:0][3:0]  b_raddr;
  logic [1:0][31:0] b_rdata;
  logic [1:0]       b_rbusy;
  logic [1:0]       b_we;
  logic [1:0][3:0]  b_waddr;
  logic [1:0][31:0] b_wdata;
  logic             b_rv;
  logic [3:0]       b_ra;
  logic             b_rr;
  logic             b_wc;

  int vectors = 0;
  int errs    = 0;

  regbank_mp dut_a (
    .clk(clk), .rst_n(rst_n),
    .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
    .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .resv_valid(a_rv), .resv_addr(a_ra), .resv_ready(a_rr),
    .wr_conflict(a_wc)
  );

  regbank_mp #(.REG_COUNT(12), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
    .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .resv_valid(b_rv), .resv_addr(b_ra), .resv_ready(b_rr),
    .wr_conflict(b_wc)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] byp_exp;

  initial begin
    rst_n = 1'b0;
    a_raddr = '0; a_we = '0; a_waddr = '0; a_wdata = '0;
    a_rv = 1'b0; a_ra = '0;
    b_raddr = '0; b_we = '0; b_waddr = '0; b_wdata = '0;
    b_rv = 1'b0; b_ra = '0;
    #2;
    chk("rst_rdata", a_rdata[0], 32'h0);
    chk("rst_rbusy", {30'h0, a_rbusy}, 32'h0);
    chk("rst_conf", {31'h0, a_wc}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    a_we = 2'b11; a_waddr = {4'd2, 4'd1};
    a_wdata = {32'h22, 32'h11};
    step();
    a_we = '0; a_raddr = {4'd2, 4'd1};
    #1;
    chk("wr_r1", a_rdata[0], 32'h11);
    chk("wr_r2", a_rdata[1], 32'h22);
    chk("no_conf", {31'h0, a_wc}, 32'h0);

    a_we = 2'b11; a_waddr = {4'd5, 4'd5};
    a_wdata = {32'hAAAA, 32'h5555};
    step();
    a_we = '0; a_raddr[0] = 4'd5;
    #1;
    chk("conf_pulse", {31'h0, a_wc}, 32'h1);
    chk("conf_win", a_rdata[0], 32'hAAAA);
    step();
    chk("conf_end", {31'h0, a_wc}, 32'h0);

    a_rv = 1'b1; a_ra = 4'd3; a_raddr[0] = 4'd3;
    #1;
    chk("resv_rdy", {31'h0, a_rr}, 32'h1);
    step();
    chk("resv_busy", {31'h0, a_rbusy[0]}, 32'h1);
    chk("resv_again", {31'h0, a_rr}, 32'h0);
    a_rv = 1'b0;
    a_we = 2'b01; a_waddr[0] = 4'd3; a_wdata[0] = 32'h12;
    step();
    a_we = '0;
    #1;
    chk("wb_clr", {31'h0, a_rbusy[0]}, 32'h0);
    chk("wb_data", a_rdata[0], 32'h12);

    a_rv = 1'b1; a_ra = 4'd7;
    a_we = 2'b10; a_waddr[1] = 4'd7; a_wdata[1] = 32'h99;
    #1;
    chk("setw_rdy", {31'h0, a_rr}, 32'h1);
    step();
    a_rv = 1'b0; a_we = '0; a_raddr[1] = 4'd7;
    #1;
    chk("setw_data", a_rdata[1], 32'h99);
    chk("setw_busy", {31'h0, a_rbusy[1]}, 32'h1);

`ifdef REGBANK_BYPASS_EN
    byp_exp = 32'hBEEF;
`else
    byp_exp = 32'h0;
`endif
    a_raddr[0] = 4'd4;
    a_we = 2'b01; a_waddr[0] = 4'd4; a_wdata[0] = 32'hBEEF;
    #1;
    chk("bypass", a_rdata[0], byp_exp);
    step();
    a_we = '0;
    #1;
    chk("bypass_nx", a_rdata[0], 32'hBEEF);

    b_we = 2'b11; b_waddr = {4'd0, 4'd0};
    b_wdata = {32'h1234, 32'hFFFF};
    step();
    b_we = '0; b_raddr = {4'd0, 4'd0};
    #1;
    chk("z_noconf", {31'h0, b_wc}, 32'h0);
    chk("z_rdata", b_rdata[0], 32'h0);
    b_we = 2'b11; b_waddr = {4'd11, 4'd13};
    b_wdata = {32'hB, 32'h1};
    step();
    b_we = '0; b_raddr = {4'd11, 4'd13};
    #1;
    chk("oor_rdata", b_rdata[0], 32'h0);
    chk("r11_data", b_rdata[1], 32'hB);
    b_rv = 1'b1; b_ra = 4'd0;
    #1;
    chk("z_resv", {31'h0, b_rr}, 32'h1);
    step();
    b_raddr[0] = 4'd0;
    #1;
    chk("z_busy", {31'h0, b_rbusy[0]}, 32'h0);
    b_ra = 4'd14;
    #1;
    chk("oor_resv", {31'h0, b_rr}, 32'h0);
    b_ra = 4'd11;
    step();
    b_rv = 1'b0;
    #1;
    chk("b_busy11", {31'h0, b_rbusy[1]}, 32'h1);

    a_we = 2'b11; a_waddr = {4'd5, 4'd5};
    a_wdata = {32'h1, 32'h2};
    step();
    a_we = '0; a_raddr = {4'd7, 4'd5};
    #1;
    chk("pre_rst_conf", {31'h0, a_wc}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_conf", {31'h0, a_wc}, 32'h0);
    chk("mid_rst_r5", a_rdata[0], 32'h0);
    chk("mid_rst_r7", a_rdata[1], 32'h0);
    chk("mid_rst_busy", {30'h0, a_rbusy}, 32'h0);
    chk("mid_rst_b11", {31'h0, b_rbusy[1]}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
